mon_graph_ctrl: RTL

MON_GRAPH_CTRL -- requirements
Module: mon_graph_ctrl

---
 rtl/mon_graph_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/mon_graph_ctrl.sv
// Monitor/host RAM arbiter: drains lookup pipeline, runs host writes, resumes.
// Optional load checksum register built when MON_LOAD_CSUM_EN is defined.
module mon_graph_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int ADDR_W       = 11
) (
  input  logic              core_sp_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mon_addr,
  input  logic              host_req,
  input  logic              host_sel,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        bb_we,
  output logic [3:0]        nh_we,
  output logic              mon_stall,
  output logic              fifo_flush,
  output logic [31:0]       load_csum
);

  typedef enum logic [1:0] {
    MON,
    DRAIN,
    LOAD,
    RESUME
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       acked;
  logic       write;

  // A write is refused on the cycle right after an ack.
  assign write = (state == LOAD) && host_req && !acked;

  always_ff @(posedge core_sp_clk or negedge reset) begin
    if (!reset) begin
      state <= MON;
      cnt   <= '0;
      acked <= 1'b0;
    end else begin
      acked <= write;
      unique case (state)
        MON: begin
          if (host_req) begin
            state <= DRAIN;
            cnt   <= CNT_INIT;
          end
        end
        DRAIN: begin
          if (cnt == 4'd0) state <= LOAD;
          else cnt <= cnt - 4'd1;
        end
        LOAD: begin
          if (!host_req) state <= RESUME;
        end
        RESUME: state <= MON;
        default: state <= MON;
      endcase
    end
  end

  assign ram_addr   = (state == LOAD && host_req) ? host_addr : mon_addr;
  assign ram_wdata  = write ? host_wdata : 32'h0;
  assign bb_we      = (write && !host_sel) ? 4'hF : 4'h0;
  assign nh_we      = (write && host_sel) ? 4'hF : 4'h0;
  assign host_ack   = write;
  assign mon_stall  = (state != MON);
  assign fifo_flush = (state == RESUME);

`ifdef MON_LOAD_CSUM_EN
  logic [31:0] csum;

  always_ff @(posedge core_sp_clk or negedge reset) begin
    if (!reset) begin
      csum <= '0;
    end else if (state == DRAIN && cnt == 4'd0) begin
      csum <= '0;
    end else if (write) begin
      csum <= csum ^ host_wdata;
    end
  end

  assign load_csum = csum;
`else
  assign load_csum = 32'h0;
`endif

endmodule
